cve2_data_obi_demux: RTL

- Sits directly downstream of the core top's data memory port. It consumes the core's req/gnt/rvalid transactions and routes them by address to two slave ports: slave 0 is the tightly coupled RAM, slave 1 is the peripheral bus.
- Unmapped addresses go to an internal error responder.
- Responses return strictly in request order; to guarantee this, the block blocks a target switch while any transaction is outstanding.

---
 rtl/cve2_pkg.sv | 10 +
 rtl/cve2_obi_err_resp.sv | 28 ++
 rtl/cve2_data_obi_demux.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cve2_pkg.sv
// Shared core types; the data-side OBI demux uses obi_tgt_e to name its routing targets.
package cve2_pkg;

  typedef enum logic [1:0] {
    TgtS0  = 2'd0,
    TgtS1  = 2'd1,
    TgtErr = 2'd2
  } obi_tgt_e;

endpackage

// File: rtl/cve2_obi_err_resp.sv
// Error responder for unmapped addresses: grants immediately, answers with
// rvalid+err and zero data exactly one cycle after each accepted request.
module cve2_obi_err_resp (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_req,
  output logic        o_gnt,
  output logic        o_rvalid,
  output logic        o_err,
  output logic [31:0] o_rdata
);

  logic r_pend;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= i_req;
    end
  end

  assign o_gnt    = 1'b1;
  assign o_rvalid = r_pend;
  assign o_err    = r_pend;
  assign o_rdata  = '0;

endmodule

// File: rtl/cve2_data_obi_demux.sv
// Routes core data-port OBI transactions to the TCM (s0), the peripheral bus (s1)
// or an internal error responder; target switches wait until nothing is outstanding.
module cve2_data_obi_demux
  import cve2_pkg::*;
#(
  parameter logic [31:0] S0Base         = 32'h0000_0000,
  parameter logic [31:0] S0Mask         = 32'hFFF0_0000,
  parameter logic [31:0] S1Base         = 32'h1000_0000,
  parameter logic [31:0] S1Mask         = 32'hF000_0000,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        core_req_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,

  output logic        s0_req_o,
  input  logic        s0_gnt_i,
  input  logic        s0_rvalid_i,
  output logic        s0_we_o,
  output logic [3:0]  s0_be_o,
  output logic [31:0] s0_addr_o,
  output logic [31:0] s0_wdata_o,
  input  logic [31:0] s0_rdata_i,
  input  logic        s0_err_i,

  output logic        s1_req_o,
  input  logic        s1_gnt_i,
  input  logic        s1_rvalid_i,
  output logic        s1_we_o,
  output logic [3:0]  s1_be_o,
  output logic [31:0] s1_addr_o,
  output logic [31:0] s1_wdata_o,
  input  logic [31:0] s1_rdata_i,
  input  logic        s1_err_i,

  output logic        protocol_err_o
);

  localparam int unsigned   CntW   = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic [CntW-1:0] r_cnt;
  obi_tgt_e        r_last_tgt;
  logic            r_proto_err;

  obi_tgt_e        w_tgt;
  logic            w_allow;
  logic            w_tgt_gnt;
  logic            w_hs;
  logic            w_cnt_zero;

  logic            w_err_gnt;
  logic            w_err_rvalid;
  logic            w_err_err;
  logic [31:0]     w_err_rdata;

  logic            w_rvalid;
  logic [31:0]     w_rdata;
  logic            w_rerr;
  logic            w_unexp;

  // S0 is tested first so it wins when the two windows overlap.
  always_comb begin
    w_tgt = TgtErr;
    if ((core_addr_i & S0Mask) == S0Base) begin
      w_tgt = TgtS0;
    end else if ((core_addr_i & S1Mask) == S1Base) begin
      w_tgt = TgtS1;
    end
  end

  assign w_cnt_zero = (r_cnt == '0);
  assign w_allow    = w_cnt_zero | ((w_tgt == r_last_tgt) & (r_cnt < MaxCnt));

  always_comb begin
    w_tgt_gnt = w_err_gnt;
    case (w_tgt)
      TgtS0:   w_tgt_gnt = s0_gnt_i;
      TgtS1:   w_tgt_gnt = s1_gnt_i;
      default: w_tgt_gnt = w_err_gnt;
    endcase
  end

  assign s0_req_o   = core_req_i & w_allow & (w_tgt == TgtS0);
  assign s1_req_o   = core_req_i & w_allow & (w_tgt == TgtS1);
  assign core_gnt_o = core_req_i & w_allow & w_tgt_gnt;
  assign w_hs       = core_gnt_o;

  assign s0_we_o    = core_we_i;
  assign s0_be_o    = core_be_i;
  assign s0_addr_o  = core_addr_i;
  assign s0_wdata_o = core_wdata_i;
  assign s1_we_o    = core_we_i;
  assign s1_be_o    = core_be_i;
  assign s1_addr_o  = core_addr_i;
  assign s1_wdata_o = core_wdata_i;

  cve2_obi_err_resp u_err_resp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_req    (w_hs & (w_tgt == TgtErr)),
    .o_gnt    (w_err_gnt),
    .o_rvalid (w_err_rvalid),
    .o_err    (w_err_err),
    .o_rdata  (w_err_rdata)
  );

  // A slave response is only forwarded when it comes from the current target
  // and something is actually outstanding; anything else is dropped.
  always_comb begin
    w_rvalid = 1'b0;
    w_rdata  = '0;
    w_rerr   = 1'b0;
    case (r_last_tgt)
      TgtS0: begin
        w_rvalid = s0_rvalid_i & ~w_cnt_zero;
        w_rdata  = s0_rdata_i;
        w_rerr   = s0_err_i;
      end
      TgtS1: begin
        w_rvalid = s1_rvalid_i & ~w_cnt_zero;
        w_rdata  = s1_rdata_i;
        w_rerr   = s1_err_i;
      end
      default: begin
        w_rvalid = w_err_rvalid;
        w_rdata  = w_err_rdata;
        w_rerr   = w_err_err;
      end
    endcase
  end

  assign core_rvalid_o = w_rvalid;
  assign core_rdata_o  = w_rvalid ? w_rdata : '0;
  assign core_err_o    = w_rvalid & w_rerr;

  assign w_unexp = (s0_rvalid_i & ((r_last_tgt != TgtS0) | w_cnt_zero))
                 | (s1_rvalid_i & ((r_last_tgt != TgtS1) | w_cnt_zero));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt       <= '0;
      r_last_tgt  <= TgtS0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_hs && !w_rvalid) begin
        r_cnt <= r_cnt + CntW'(1);
      end else if (w_rvalid && !w_hs) begin
        r_cnt <= r_cnt - CntW'(1);
      end
      if (w_hs) begin
        r_last_tgt <= w_tgt;
      end
      if (w_unexp) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign protocol_err_o = r_proto_err;

endmodule
